// File: rtl/fetch_unit_pkg.sv
// Shared widths and the buffered-entry type for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int unsigned RV32_ADDR_WIDTH         = 32;
    localparam int unsigned IMEM_DATA_WIDTH         = 64;
    localparam int unsigned PC_STEP                 = IMEM_DATA_WIDTH / 8;
    localparam int unsigned PC_SHIFT                = $clog2(PC_STEP);
    localparam int unsigned FETCH_BUF_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [RV32_ADDR_WIDTH-1:0] pc;
        logic [IMEM_DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Clear the byte-offset bits so a PC points at the start of its packet.
    function automatic logic [RV32_ADDR_WIDTH-1:0] align_pc(input logic [RV32_ADDR_WIDTH-1:0] pc);
        return {pc[RV32_ADDR_WIDTH-1:PC_SHIFT], {PC_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Flushable synchronous FIFO of fetched {pc, packet} entries; flush beats push and pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUF_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = $bits(fetch_entry_t)
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop_ok;

    assign pop_ok    = pop && (cnt != '0);
    assign head_data = mem[rd_ptr];
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop_ok);
        end
    end

    // Storage is deliberately left unreset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, single in-flight imem read tracking, and issue throttling in front of the fetch buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [RV32_ADDR_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned                FETCH_BUF_DEPTH = FETCH_BUF_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [RV32_ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [IMEM_DATA_WIDTH-1:0] i_imem_rd_data,
    input  logic                       i_redirect_valid,
    input  logic [RV32_ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                       o_valid,
    output logic [RV32_ADDR_WIDTH-1:0] o_pc,
    output logic [IMEM_DATA_WIDTH-1:0] o_inst,
    input  logic                       i_ready
);

    localparam int unsigned CW = $clog2(FETCH_BUF_DEPTH) + 1;

    logic [RV32_ADDR_WIDTH-1:0] r_pc;
    logic [RV32_ADDR_WIDTH-1:0] inflight_pc;
    logic                       inflight;
    logic [CW-1:0]              buf_cnt;
    logic [CW:0]                occupancy;
    logic                       issue;
    fetch_entry_t               push_entry;
    fetch_entry_t               head_entry;

    assign occupancy   = {1'b0, buf_cnt} + (CW + 1)'(inflight);
    assign issue       = !rst && !i_redirect_valid && (occupancy < (CW + 1)'(FETCH_BUF_DEPTH));
    assign o_imem_addr = r_pc >> PC_SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= align_pc(RESET_PC);
            inflight <= 1'b0;
        end else if (i_redirect_valid) begin
            r_pc     <= align_pc(i_redirect_pc);
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= r_pc;
            r_pc        <= r_pc + RV32_ADDR_WIDTH'(PC_STEP);
        end else begin
            inflight <= 1'b0;
        end
    end

    assign push_entry.pc   = inflight_pc;
    assign push_entry.inst = i_imem_rd_data;

    fetch_fifo #(
        .DEPTH (FETCH_BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .flush     (rst || i_redirect_valid),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (o_valid && i_ready),
        .head_data (head_entry),
        .count     (buf_cnt)
    );

    assign o_valid = (buf_cnt != '0);
    assign o_pc    = head_entry.pc;
    assign o_inst  = head_entry.inst;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that sits directly upstream of the instruction memory. Owns the fetch PC, drives the imem read address every cycle, captures the packet returned one cycle later into a small flushable fetch buffer, and presents packets to decode through a valid/ready handshake. Branch/exception redirects flush all buffered and in-flight packets and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte PC fetched first after reset; low `PC_SHIFT` bits ignored.
- `FETCH_BUF_DEPTH`, default 4: fetch buffer entries; power of two, ≥2. Full throughput needs ≥3.
- `clk`  input  1  clock; all state updates on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `o_imem_addr`  output  `RV32_ADDR_WIDTH`  packet index to imem: `r_pc >> PC_SHIFT`, zero-extended.
- `i_imem_rd_data`  input  `IMEM_DATA_WIDTH`  packet for the address driven in the previous cycle.
- `i_redirect_valid`  input  1  flush and restart fetch.
- `i_redirect_pc`  input  `RV32_ADDR_WIDTH`  redirect target byte PC.
- `o_valid`  output  1  buffer head holds a packet.
- `o_pc`  output  `RV32_ADDR_WIDTH`  packet-aligned byte PC of head.
- `o_inst`  output  `IMEM_DATA_WIDTH`  packet at head.
- `i_ready`  input  1  decode accepts head this cycle.

## Operation
- Packet = one imem word; step = `IMEM_DATA_WIDTH/8` bytes; `PC_SHIFT = log2(step)`.
- Imem reads every cycle with no enable. A read counts only if it is an *issue*. Non-issued reads are ignored.
- Issue condition, registered terms only: `!rst && !i_redirect_valid && (buf_cnt + inflight) < FETCH_BUF_DEPTH`.
- On issue: `inflight <= 1`, `inflight_pc <= r_pc`, `r_pc <= r_pc + step`. Else `inflight <= 0`.
- PC addition wraps modulo 2^`RV32_ADDR_WIDTH`.
- Arrival: when `inflight = 1`, write `{inflight_pc, i_imem_rd_data}` into the buffer tail. The issue condition guarantees no overflow.
- Pop: when `o_valid && i_ready`, advance the head. Push and pop in the same cycle are both performed; `buf_cnt` is unchanged.
- Redirect cycle has priority over everything:
  - Buffer emptied (pointers and `buf_cnt` to 0).
  - Arriving packet discarded.
  - No issue; `inflight <= 0`.
  - `r_pc <= {i_redirect_pc[31:PC_SHIFT], PC_SHIFT'b0}`.
  - A handshake completing in the redirect cycle is legal, but the entry is flushed regardless. Decode owns squashing it.
- Outputs `o_valid/o_pc/o_inst` come from the buffer head only, with no input-to-output combinational path. `o_valid = (buf_cnt != 0)`.
- Order is strictly preserved. No packet is dropped or duplicated except by redirect/reset.

## Timing
- Reset values:
  - `r_pc = RESET_PC` aligned, so `o_imem_addr = RESET_PC >> PC_SHIFT`.
  - `o_valid = 0`, `buf_cnt = 0`, `inflight = 0`.
  - `o_pc`/`o_inst` unspecified while `o_valid = 0` (buffer storage not reset).
- Reset mid-operation discards the buffer and in-flight read; the next cycle behaves as post-reset.
- Fetch latency: issue in cycle t → data on `i_imem_rd_data` in t+1 → `o_valid` in t+2.
- First packet after reset release (cycle 0 = first cycle with `rst = 0`): `o_valid` in cycle 2.
- Redirect asserted in cycle r: target issued in r+1, `o_valid` with target in r+3.
- Back-to-back redirects: each restarts the 3-cycle sequence; the last one wins.
- Steady state with `i_ready = 1` and depth ≥3: one packet per cycle.
- Stall: issue stops once `buf_cnt + inflight = FETCH_BUF_DEPTH`. `r_pc` and `o_imem_addr` then hold.

## Structure
- `constants.vh` gains `PC_SHIFT` and `FETCH_BUF_DEPTH_DEFAULT`, reusing `RV32_ADDR_WIDTH` and `IMEM_DATA_WIDTH`.
- Sub-module `fetch_fifo`: synchronous FIFO of `{pc, packet}` with push, pop, flush and count. Flush overrides push and pop.
- `fetch_unit` keeps the PC register, in-flight tracking and issue logic.

## Test plan
All scenarios use `IMEM_DATA_WIDTH = 64` (step 8, `PC_SHIFT = 3`), imem model preloaded with mem[i] = i.
- **Reset/stream:** `RESET_PC = 0`, `i_ready = 1` → `o_imem_addr` 0,1,2,…; `o_valid` from cycle 2; `o_pc` 0x0, 0x8, 0x10 with `o_inst` 0, 1, 2, one per cycle.
- **Backpressure:** `i_ready = 0` for cycles 3–12 → at most 4 packets buffered, `o_imem_addr` frozen, no further issue. After release, packets continue in order with no gaps or duplicates.
- **Redirect:** redirect to 0x1004 with 3 entries buffered → `o_valid = 0` for cycles r+1 and r+2; at r+3 `o_pc = 0x1000`, `o_inst = 0x200`. Stale packets never appear.
- **Redirect with handshake:** redirect and `i_ready` in the same cycle → flush wins, `buf_cnt = 0` next cycle, same r+3 timing.
- **Wrap:** `RESET_PC = 0xFFFF_FFF0` → `o_pc` sequence 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0.
- **Mid-run reset:** `rst` pulsed for 1 cycle with 2 entries buffered → `o_valid = 0` the following cycle; restarts at `RESET_PC` with post-reset timing.
